// File: rtl/hough_pkg.sv
// Shared constants and FSM encoding for the Hough accumulator peak scanner.
package hough_pkg;

   localparam int ROW_LENGTH = 450;
   localparam int COL_LENGTH = 290;
   localparam int COL_BIAS   = 95;
   localparam int ROW_BIAS   = 95;
   localparam int TOTAL      = ROW_LENGTH * COL_LENGTH;

   localparam int ADDR_W = 18;
   localparam int VOTE_W = 4;
   localparam int X_W    = 10;
   localparam int Y_W    = 9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/hough_peak_tracker.sv
// Running-maximum tracker: keeps the first cell in scan order holding the
// strictly largest vote count seen since the last init.
module hough_peak_tracker
   import hough_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              init,
   input  logic              valid,
   input  logic [VOTE_W-1:0] votes,
   input  logic [X_W-1:0]    col,
   input  logic [Y_W-1:0]    row,
   output logic [VOTE_W-1:0] best_votes,
   output logic [X_W-1:0]    best_col,
   output logic [Y_W-1:0]    best_row
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         best_votes <= '0;
         best_col   <= '0;
         best_row   <= '0;
      end else if (init) begin
         best_votes <= '0;
         best_col   <= '0;
         best_row   <= '0;
      end else if (valid && (votes > best_votes)) begin
         // strict compare: ties keep the earlier cell
         best_votes <= votes;
         best_col   <= col;
         best_row   <= row;
      end
   end

endmodule

// File: rtl/hough_peak_scanner.sv
// Scans a Hough accumulator BRAM in row-major order, reports the peak cell and
// optionally zeroes every cell one cycle behind the read stream.
module hough_peak_scanner #(
   parameter int ROW_LENGTH = hough_pkg::ROW_LENGTH,
   parameter int COL_LENGTH = hough_pkg::COL_LENGTH,
   parameter int COL_BIAS   = hough_pkg::COL_BIAS,
   parameter int ROW_BIAS   = hough_pkg::ROW_BIAS
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         clear_en,
   output logic [hough_pkg::ADDR_W-1:0] rd_addr,
   input  logic [hough_pkg::VOTE_W-1:0] rd_data,
   output logic [hough_pkg::ADDR_W-1:0] wr_addr,
   output logic [hough_pkg::VOTE_W-1:0] wr_data,
   output logic                         wr_en,
   output logic                         busy,
   output logic                         done,
   output logic [hough_pkg::X_W-1:0]    peak_x,
   output logic [hough_pkg::Y_W-1:0]    peak_y,
   output logic [hough_pkg::VOTE_W-1:0] peak_votes,
   output logic                         peak_valid
);

   import hough_pkg::*;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROW_LENGTH * COL_LENGTH - 1);
   localparam logic [X_W-1:0]    COL_LAST  = X_W'(ROW_LENGTH - 1);

   state_t              state;
   logic                clear_mode;
   logic [X_W-1:0]      col;
   logic [Y_W-1:0]      row;
   logic [X_W-1:0]      cons_col;
   logic [Y_W-1:0]      cons_row;
   logic                cons_valid;
   logic                cons_last;
   logic                last_absorbed;
   logic                accept;
   logic [VOTE_W-1:0]   best_votes;
   logic [X_W-1:0]      best_col;
   logic [Y_W-1:0]      best_row;

   assign accept  = (state == ST_IDLE) && start;
   assign wr_data = '0;

   hough_peak_tracker u_tracker (
      .clk        (clk),
      .rst_n      (rst_n),
      .init       (accept),
      .valid      (cons_valid),
      .votes      (rd_data),
      .col        (cons_col),
      .row        (cons_row),
      .best_votes (best_votes),
      .best_col   (best_col),
      .best_row   (best_row)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         clear_mode    <= 1'b0;
         col           <= '0;
         row           <= '0;
         cons_col      <= '0;
         cons_row      <= '0;
         cons_valid    <= 1'b0;
         cons_last     <= 1'b0;
         last_absorbed <= 1'b0;
         rd_addr       <= '0;
         wr_addr       <= '0;
         wr_en         <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         peak_x        <= '0;
         peak_y        <= '0;
         peak_votes    <= '0;
         peak_valid    <= 1'b0;
      end else begin
         cons_valid    <= 1'b0;
         cons_last     <= 1'b0;
         wr_en         <= 1'b0;
         done          <= 1'b0;
         // one cycle after the final word is consumed the tracker holds the answer
         last_absorbed <= cons_last;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state      <= ST_SCAN;
                  busy       <= 1'b1;
                  clear_mode <= clear_en;
                  rd_addr    <= '0;
                  col        <= '0;
                  row        <= '0;
               end
            end
            ST_SCAN: begin
               cons_valid <= 1'b1;
               cons_col   <= col;
               cons_row   <= row;
               wr_en      <= clear_mode;
               if (clear_mode) wr_addr <= rd_addr;
               if (rd_addr == LAST_ADDR) begin
                  cons_last <= 1'b1;
                  state     <= ST_DRAIN;
               end else begin
                  rd_addr <= rd_addr + ADDR_W'(1);
                  if (col == COL_LAST) begin
                     col <= '0;
                     row <= row + Y_W'(1);
                  end else begin
                     col <= col + X_W'(1);
                  end
               end
            end
            ST_DRAIN: begin
               if (last_absorbed) begin
                  state      <= ST_DONE;
                  done       <= 1'b1;
                  peak_x     <= best_col + X_W'(COL_BIAS);
                  peak_y     <= best_row + Y_W'(ROW_BIAS);
                  peak_votes <= best_votes;
                  peak_valid <= (best_votes != '0);
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hough_peak_scanner.sv
// Directed bench for hough_peak_scanner on a 4x3 accumulator with a
// behavioural 1-cycle-latency BRAM and a queue-based scoreboard.
module tb_hough_peak_scanner;

   localparam int NC = 12;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        clear_en = 1'b0;
   logic [17:0] rd_addr;
   logic [3:0]  rd_data;
   logic [17:0] wr_addr;
   logic [3:0]  wr_data;
   logic        wr_en;
   logic        busy;
   logic        done;
   logic [9:0]  peak_x;
   logic [8:0]  peak_y;
   logic [3:0]  peak_votes;
   logic        peak_valid;

   hough_peak_scanner #(
      .ROW_LENGTH (4),
      .COL_LENGTH (3),
      .COL_BIAS   (95),
      .ROW_BIAS   (95)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .clear_en   (clear_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_en      (wr_en),
      .busy       (busy),
      .done       (done),
      .peak_x     (peak_x),
      .peak_y     (peak_y),
      .peak_votes (peak_votes),
      .peak_valid (peak_valid)
   );

   // clock / reset / cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [3:0] mem [16];
   always @(posedge clk) begin
      rd_data <= mem[rd_addr[3:0]];
      if (wr_en) mem[wr_addr[3:0]] = wr_data;
   end

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [23:0] exp_q [$];
   int          start_q [$];
   logic [17:0] exp_wr_q [$];
   logic [17:0] prev_rd = '0;
   logic [23:0] e;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [23:0] pack_exp(input int x, input int y, input int v);
      logic [3:0] v4;
      logic [8:0] y9;
      logic [9:0] x10;
      v4  = 4'(v);
      y9  = 9'(y);
      x10 = 10'(x);
      return {(v != 0), v4, y9, x10};
   endfunction

   function automatic logic [23:0] model_peak();
      int best = 0;
      int bi = 0;
      for (int i = 0; i < NC; i++)
         if (int'(mem[i]) > best) begin
            best = int'(mem[i]);
            bi = i;
         end
      return pack_exp(95 + bi % 4, 95 + bi / 4, best);
   endfunction

   // monitor / scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (done) begin
            if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("peak_x", int'(peak_x), int'(e[9:0]));
               chk("peak_y", int'(peak_y), int'(e[18:10]));
               chk("peak_votes", int'(peak_votes), int'(e[22:19]));
               chk("peak_valid", int'(peak_valid), int'(e[23]));
               chk("busy_at_done", int'(busy), 1);
               if (start_q.size() > 0) chk("done_latency", cyc - start_q.pop_front(), 14);
               else chk("missing_start_record", 1, 0);
            end
         end
         if (wr_en) begin
            if (exp_wr_q.size() == 0) chk("unexpected_write", int'(wr_addr), -1);
            else begin
               chk("wr_addr", int'(wr_addr), int'(exp_wr_q.pop_front()));
               chk("wr_trails_rd", int'(wr_addr), int'(prev_rd));
               chk("wr_data", int'(wr_data), 0);
            end
         end
         prev_rd = rd_addr;
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 50 && busy; i++) @(negedge clk);
      if (busy) chk("idle_timeout", 1, 0);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) break;
      end
      if (!done) chk("done_timeout", 0, 1);
   endtask

   task automatic run_scan(input logic clr, input logic [23:0] exp, input bit mid_pulse);
      wait_idle();
      @(negedge clk);
      start = 1'b1;
      clear_en = clr;
      if (clr) for (int k = 0; k < NC; k++) exp_wr_q.push_back(18'(k));
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      start_q.push_back(cyc);
      chk("busy_after_start", int'(busy), 1);
      @(negedge clk);
      start = 1'b0;
      clear_en = 1'b0;
      if (mid_pulse) begin
         repeat (3) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      wait_done();
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_rd_addr"}, int'(rd_addr), 0);
      chk({tag, "_wr_addr"}, int'(wr_addr), 0);
      chk({tag, "_wr_en"}, int'(wr_en), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_peak_x"}, int'(peak_x), 0);
      chk({tag, "_peak_y"}, int'(peak_y), 0);
      chk({tag, "_peak_votes"}, int'(peak_votes), 0);
      chk({tag, "_peak_valid"}, int'(peak_valid), 0);
   endtask

   initial begin
      int s;
      int dones;
      logic [3:0] pat [NC];
      logic [23:0] rexp;

      for (int i = 0; i < 16; i++) mem[i] = 4'd0;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst_n = 1'b1;

      // all zero, no clear
      run_scan(1'b0, pack_exp(95, 95, 0), 1'b0);

      // single peak at cell 6, with a start pulse mid-scan
      pat = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd9, 4'd8, 4'd7, 4'd0, 4'd3, 4'd8};
      for (int i = 0; i < NC; i++) mem[i] = pat[i];
      run_scan(1'b0, pack_exp(97, 96, 9), 1'b1);
      repeat (5) @(negedge clk);
      chk("hold_peak_votes", int'(peak_votes), 9);
      chk("hold_peak_x", int'(peak_x), 97);
      chk("hold_peak_y", int'(peak_y), 96);

      // saturated tie: first occurrence wins
      for (int i = 0; i < NC; i++) mem[i] = 4'($urandom_range(0, 14));
      mem[2] = 4'd15;
      mem[10] = 4'd15;
      run_scan(1'b0, pack_exp(97, 95, 15), 1'b0);

      // random contents with clear
      for (int i = 0; i < NC; i++) mem[i] = 4'($urandom_range(0, 15));
      mem[5] = 4'd14;
      rexp = model_peak();
      run_scan(1'b1, rexp, 1'b0);
      repeat (3) @(negedge clk);
      chk("writes_consumed", exp_wr_q.size(), 0);
      for (int i = 0; i < NC; i++) chk("cleared_cell", int'(mem[i]), 0);
      run_scan(1'b0, pack_exp(95, 95, 0), 1'b0);

      // reset in the middle of a clear scan
      for (int i = 0; i < NC; i++) mem[i] = 4'(i + 1);
      wait_idle();
      @(negedge clk);
      start = 1'b1;
      clear_en = 1'b1;
      for (int k = 0; k < 4; k++) exp_wr_q.push_back(18'(k));
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      clear_en = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("midreset");
      for (int i = 0; i < NC; i++) chk("after_reset_cell", int'(mem[i]), (i < 4) ? 0 : i + 1);
      chk("midreset_writes", exp_wr_q.size(), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // start held high: back-to-back scans, peak in the last cell
      for (int i = 0; i < NC; i++) mem[i] = 4'd0;
      mem[11] = 4'd5;
      @(negedge clk);
      start = 1'b1;
      exp_q.push_back(pack_exp(98, 97, 5));
      exp_q.push_back(pack_exp(98, 97, 5));
      @(posedge clk);
      #1;
      s = cyc;
      start_q.push_back(s);
      start_q.push_back(s + 16);
      dones = 0;
      for (int i = 0; i < 60 && dones < 2; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      start = 1'b0;
      chk("b2b_done_count", dones, 2);

      repeat (20) @(negedge clk);
      chk("exp_q_drained", exp_q.size(), 0);
      chk("start_q_drained", start_q.size(), 0);
      chk("final_idle", int'(busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule
